uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares one uart_tx transmitter among NUM_REQ byte producers. It grants one requester, issues a one-cycle write/data strobe to uart_tx, and tracks the transmitter through busy and back to ready using uart_tx's txrdy. It supports packet locking so a multi-byte message goes out without interleaving. It sits between the producer blocks and uart_tx, in the mclkx16 domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), width of grant_id (derived; do not override)
BUSY_WAIT, 32, max mclkx16 cycles to wait for txrdy to fall after a write strobe
MAX_BURST, 16, max consecutive bytes one locked requester may send before forced re-arbitration

Ports:
mclkx16  in  1  clock, same clock as uart_tx
reset  in  1  synchronous, active-low reset
req  in  NUM_REQ  per-requester byte-valid; held with data until ack
req_data  in  8*NUM_REQ  byte for requester i on bits [8i+7:8i]
req_last  in  NUM_REQ  byte is the final byte of a packet (1 = release lock after it)
ack  out  NUM_REQ  one-cycle pulse: byte from requester i accepted
grant_valid  out  1  a requester currently owns the transmitter
grant_id  out  ID_W  index of current owner (valid when grant_valid)
uart_write  out  1  one-cycle write strobe to uart_tx
uart_data  out  8  byte to uart_tx, stable from strobe until next strobe
uart_txrdy  in  1  uart_tx ready/idle flag
timeout_err  out  1  sticky: txrdy never fell within BUSY_WAIT after a strobe

Behaviour:
- Reset (reset==0 at an edge): all outputs 0, uart_data=0, rr_ptr=0, lock cleared, burst count 0, state IDLE. Applies mid-transfer: the next edge drops uart_write/ack; no retry of the interrupted byte.
- States: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE: if uart_txrdy==1 and req!=0, select the first i with req[i]==1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ. At the next edge:
  - uart_write=1 and ack[i]=1 for exactly one cycle.
  - uart_data=req_data[i]; grant_id=i; grant_valid=1.
  - lock = ~req_last[i]; burst=1; counter=0; state -> WAIT_BUSY.
  - If uart_txrdy==0, stay in IDLE, issue no strobe, and keep grant_valid=0.
- Latency: decision-to-strobe is 1 cycle. No combinational path from req to ack.
- WAIT_BUSY: counter increments each cycle.
  - uart_txrdy==0 -> WAIT_DONE.
  - counter==BUSY_WAIT-1 with txrdy still 1 -> set timeout_err (sticky until reset), then -> WAIT_DONE.
- WAIT_DONE: wait for uart_txrdy==1. Then:
  - If lock==1, req[grant_id]==1 and burst<MAX_BURST: issue the next byte from the same requester as in IDLE (strobe+ack next edge), burst+1, lock=~req_last, -> WAIT_BUSY. rr_ptr is unchanged.
  - Otherwise: rr_ptr=(grant_id+1) mod NUM_REQ, grant_valid=0, lock cleared, -> IDLE.
- Lock release: req[grant_id] dropping while locked releases the lock at the WAIT_DONE exit; no error.
- Forced release: when burst==MAX_BURST, re-arbitrate even if lock==1. The requester re-competes in IDLE via normal round-robin.
- Simultaneous events: several requests in one cycle resolve by round-robin only. Requests arriving during WAIT_* are held off by the requester, never dropped.
- At most one ack bit is high per cycle. ack and uart_write are always coincident.
- uart_data changes only on a strobe cycle.
- Throughput: one byte per uart_tx frame plus 1 idle cycle (IDLE pass) between unlocked grants; locked bytes have no extra cycle.

Test Plan:
- Single requester: reset low 2 cycles, then req[0]=1, data 8'h07, req_last=1. Required: uart_write and ack[0] pulse together for one cycle; uart_data=8'h07; tx line (real uart_tx) shows 8'h07 LSB-first; grant_valid returns to 0 and rr_ptr=1.
- Round-robin: req=4'b1111, all req_last=1, data A0..A3 held. Required: grant order 0,1,2,3,0; each ack exactly once per byte; one uart_write per ack.
- Packet lock: req[1] sends 3 bytes 11,22,33 (last on 33) while req[2] is continuously requesting. Required: the uart_tx stream is 11,22,33,then the req[2] byte; grant_id stays 1 for all three.
- Burst cap: MAX_BURST=4, req[0] sends 10 bytes with req_last=0 and req[3] is active. Required: after 4 bytes from 0, one byte from 3 is granted, then 0 resumes.
- Timeout: uart_txrdy model stuck at 1 after the strobe. Required: timeout_err=1 exactly BUSY_WAIT cycles after the strobe; timeout_err stays 1 until reset.
- Reset mid-frame: assert reset during WAIT_DONE of a locked packet. Required: next edge has all outputs 0 and lock cleared; after release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ producers, with packet locking and a burst cap.
// Latency: grant to write/ack strobe is 1 cycle. Backpressure: requesters hold req/data until ack; txrdy paces grants.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = $clog2(NUM_REQ),
    parameter int BUSY_WAIT = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                 mclkx16,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 grant_valid,
    output logic [ID_W-1:0]      grant_id,
    output logic                 uart_write,
    output logic [7:0]           uart_data,
    input  logic                 uart_txrdy,
    output logic                 timeout_err
);

    localparam int CNT_W = $clog2(BUSY_WAIT + 1);
    localparam int BST_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t             r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic               r_lock;
    logic [BST_W-1:0]   r_burst;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_REQ-1:0] r_ack;
    logic               r_write;
    logic [7:0]         r_data;
    logic [ID_W-1:0]    r_gid;
    logic               r_gvld;
    logic               r_terr;

    state_t             w_state_nxt;
    logic [ID_W-1:0]    w_rr_nxt;
    logic               w_lock_nxt;
    logic [BST_W-1:0]   w_burst_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [NUM_REQ-1:0] w_ack_nxt;
    logic               w_write_nxt;
    logic [7:0]         w_data_nxt;
    logic [ID_W-1:0]    w_gid_nxt;
    logic               w_gvld_nxt;
    logic               w_terr_nxt;

    logic               w_found;
    logic [ID_W-1:0]    w_sel;
    logic [ID_W-1:0]    w_idx;
    logic               w_issue;
    logic [ID_W-1:0]    w_issue_id;
    logic [7:0]         w_bytes [NUM_REQ];

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            w_bytes[k] = req_data[8*k +: 8];
        end
    end

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_lock_nxt  = r_lock;
        w_burst_nxt = r_burst;
        w_cnt_nxt   = r_cnt;
        w_ack_nxt   = '0;
        w_write_nxt = 1'b0;
        w_data_nxt  = r_data;
        w_gid_nxt   = r_gid;
        w_gvld_nxt  = r_gvld;
        w_terr_nxt  = r_terr;
        w_issue     = 1'b0;
        w_issue_id  = w_sel;

        case (r_state)
            S_IDLE: begin
                if (uart_txrdy && w_found) begin
                    w_issue     = 1'b1;
                    w_issue_id  = w_sel;
                    w_burst_nxt = BST_W'(1);
                end
            end
            S_WAIT_BUSY: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (!uart_txrdy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_cnt == CNT_W'(BUSY_WAIT - 1)) begin
                    w_terr_nxt  = 1'b1;
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (uart_txrdy) begin
                    if (r_lock && req[r_gid] && (r_burst < BST_W'(MAX_BURST))) begin
                        w_issue     = 1'b1;
                        w_issue_id  = r_gid;
                        w_burst_nxt = r_burst + BST_W'(1);
                    end else begin
                        // Unlocked, abandoned or burst-capped: hand priority to the next index.
                        w_rr_nxt    = (r_gid == ID_W'(NUM_REQ - 1)) ? '0 : r_gid + ID_W'(1);
                        w_gvld_nxt  = 1'b0;
                        w_lock_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_issue) begin
            w_ack_nxt[w_issue_id] = 1'b1;
            w_write_nxt           = 1'b1;
            w_data_nxt            = w_bytes[w_issue_id];
            w_gid_nxt             = w_issue_id;
            w_gvld_nxt            = 1'b1;
            w_lock_nxt            = ~req_last[w_issue_id];
            w_cnt_nxt             = '0;
            w_state_nxt           = S_WAIT_BUSY;
        end
    end

    always_ff @(posedge mclkx16) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_lock   <= 1'b0;
            r_burst  <= '0;
            r_cnt    <= '0;
            r_ack    <= '0;
            r_write  <= 1'b0;
            r_data   <= '0;
            r_gid    <= '0;
            r_gvld   <= 1'b0;
            r_terr   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_lock   <= w_lock_nxt;
            r_burst  <= w_burst_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ack    <= w_ack_nxt;
            r_write  <= w_write_nxt;
            r_data   <= w_data_nxt;
            r_gid    <= w_gid_nxt;
            r_gvld   <= w_gvld_nxt;
            r_terr   <= w_terr_nxt;
        end
    end

    assign ack         = r_ack;
    assign uart_write  = r_write;
    assign uart_data   = r_data;
    assign grant_id    = r_gid;
    assign grant_valid = r_gvld;
    assign timeout_err = r_terr;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: producer queues, a txrdy model of uart_tx, expected grants in order.
module tb_uart_tx_arbiter;

    localparam int NR    = 4;
    localparam int BW    = 8;
    localparam int MB    = 4;
    localparam int FRAME = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0]   req_last = '0;
    logic [NR-1:0]   ack;
    logic            grant_valid;
    logic [1:0]      grant_id;
    logic            uart_write;
    logic [7:0]      uart_data;
    logic            txrdy = 1'b1;
    logic            timeout_err;
    logic            stuck_hi = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ   (NR),
        .BUSY_WAIT (BW),
        .MAX_BURST (MB)
    ) dut (
        .mclkx16     (clk),
        .reset       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .req_last    (req_last),
        .ack         (ack),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .uart_write  (uart_write),
        .uart_data   (uart_data),
        .uart_txrdy  (txrdy),
        .timeout_err (timeout_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // sb_q entries {id, data}; rq entries {id, last, data} in producer order.
    logic [9:0]  sb_q [$];
    logic [10:0] rq   [$];
    logic [9:0]  sb_e;
    int          busy = 0;

    // uart_tx stand-in: txrdy drops after a strobe and returns FRAME cycles later.
    always @(negedge clk) begin
        if (stuck_hi) begin
            txrdy = 1'b1;
            busy  = 0;
        end else if (uart_write) begin
            txrdy = 1'b0;
            busy  = FRAME;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) txrdy = 1'b1;
        end
    end

    // Scoreboard check on each strobe, then producers pop acked bytes and re-present.
    always @(negedge clk) begin
        if (uart_write || ack != '0) begin
            if (sb_q.size() == 0) begin
                chk("sb_extra", {27'b0, uart_write, ack}, 32'h0);
            end else begin
                sb_e = sb_q.pop_front();
                chk("sb_write", {31'b0, uart_write}, 32'h1);
                chk("sb_ack",   {28'b0, ack}, 32'h1 << sb_e[9:8]);
                chk("sb_id",    {30'b0, grant_id}, {30'b0, sb_e[9:8]});
                chk("sb_data",  {24'b0, uart_data}, {24'b0, sb_e[7:0]});
                chk("sb_gvld",  {31'b0, grant_valid}, 32'h1);
            end
            for (int i = 0; i < NR; i++) begin
                if (ack[i]) begin
                    for (int j = 0; j < rq.size(); j++) begin
                        if (int'(rq[j][10:9]) == i) begin
                            rq.delete(j);
                            break;
                        end
                    end
                end
            end
        end
        req      = '0;
        req_data = '0;
        req_last = '0;
        for (int j = 0; j < rq.size(); j++) begin
            if (!req[rq[j][10:9]]) begin
                req[rq[j][10:9]]             = 1'b1;
                req_last[rq[j][10:9]]        = rq[j][8];
                req_data[8*rq[j][10:9] +: 8] = rq[j][7:0];
            end
        end
    end

    task automatic expect_byte(input int id, input logic [7:0] d);
        sb_q.push_back({2'(id), d});
    endtask

    task automatic load(input int id, input logic [7:0] d, input logic last);
        rq.push_back({2'(id), last, d});
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        rq.delete();
        sb_q.delete();
        @(negedge clk);
        chk("rst_ack",  {28'b0, ack}, 32'h0);
        chk("rst_wr",   {31'b0, uart_write}, 32'h0);
        chk("rst_gvld", {31'b0, grant_valid}, 32'h0);
        chk("rst_gid",  {30'b0, grant_id}, 32'h0);
        chk("rst_data", {24'b0, uart_data}, 32'h0);
        chk("rst_terr", {31'b0, timeout_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && rq.size() == 0 && !grant_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, {31'b0, ok}, 32'h1);
    endtask

    task automatic wait_strobe(input string tag);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (uart_write) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, {31'b0, ok}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_dut();

        // Single requester, then rr_ptr must have moved to 1.
        @(negedge clk);
        expect_byte(0, 8'h07);
        load(0, 8'h07, 1'b1);
        drain("t1_single");
        expect_byte(1, 8'h91);
        expect_byte(0, 8'h90);
        load(0, 8'h90, 1'b1);
        load(1, 8'h91, 1'b1);
        drain("t1_rr_ptr");

        // Round-robin with all four requesting.
        reset_dut();
        expect_byte(0, 8'hA0);
        expect_byte(1, 8'hA1);
        expect_byte(2, 8'hA2);
        expect_byte(3, 8'hA3);
        expect_byte(0, 8'hB0);
        load(0, 8'hA0, 1'b1);
        load(1, 8'hA1, 1'b1);
        load(2, 8'hA2, 1'b1);
        load(3, 8'hA3, 1'b1);
        load(0, 8'hB0, 1'b1);
        drain("t2_rr");

        // Locked packet from 1 is not interleaved with 2.
        reset_dut();
        expect_byte(1, 8'h11);
        expect_byte(1, 8'h22);
        expect_byte(1, 8'h33);
        expect_byte(2, 8'h55);
        load(2, 8'h55, 1'b1);
        load(1, 8'h11, 1'b0);
        load(1, 8'h22, 1'b0);
        load(1, 8'h33, 1'b1);
        drain("t3_lock");

        // Burst cap of 4 lets requester 3 in between.
        reset_dut();
        for (int k = 0; k < 4; k++) expect_byte(0, 8'(8'h40 + k));
        expect_byte(3, 8'h3C);
        for (int k = 4; k < 10; k++) expect_byte(0, 8'(8'h40 + k));
        for (int k = 0; k < 10; k++) load(0, 8'(8'h40 + k), 1'b0);
        load(3, 8'h3C, 1'b1);
        drain("t4_burst");

        // txrdy stuck high: timeout exactly BW cycles after the strobe, sticky.
        reset_dut();
        stuck_hi = 1'b1;
        expect_byte(2, 8'h5A);
        load(2, 8'h5A, 1'b1);
        wait_strobe("t5_strobe");
        for (int k = 1; k <= BW; k++) begin
            @(negedge clk);
            if (k == BW - 1) chk("t5_terr_early", {31'b0, timeout_err}, 32'h0);
            if (k == BW)     chk("t5_terr_set",   {31'b0, timeout_err}, 32'h1);
        end
        drain("t5_drain");
        stuck_hi = 1'b0;
        expect_byte(2, 8'h5B);
        load(2, 8'h5B, 1'b1);
        drain("t5_drain2");
        chk("t5_terr_sticky", {31'b0, timeout_err}, 32'h1);

        // Reset in WAIT_DONE of a locked packet; arbitration restarts at 0.
        reset_dut();
        expect_byte(0, 8'h70);
        load(0, 8'h70, 1'b1);
        drain("t6_pre");
        expect_byte(1, 8'h61);
        load(1, 8'h61, 1'b0);
        load(1, 8'h62, 1'b0);
        load(1, 8'h63, 1'b1);
        wait_strobe("t6_strobe");
        @(negedge clk);
        chk("t6_locked_gvld", {31'b0, grant_valid}, 32'h1);
        reset_dut();
        expect_byte(0, 8'h80);
        expect_byte(2, 8'h82);
        load(2, 8'h82, 1'b1);
        load(0, 8'h80, 1'b1);
        drain("t6_restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
